// File: rtl/scan_mux.sv
// scan_mux: registered channel selector with hold, manual, auto-scan and
// single-sweep modes. Select, data and one-hot decode all update together
// on the clock edge, so dout always matches the channel named by sel_out.
//
// Handshake note: there is no backpressure. valid marks the cycle in which
// dout holds a freshly sampled channel. busy is high while a sweep is in
// flight. done pulses for exactly one cycle, alongside the last channel's
// sample of a sweep that was not aborted.
module scan_mux #(
  parameter int CH   = 8,
  parameter int W    = 1,
  parameter int SELW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] din,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel_in,
  input  logic            load,
  input  logic            start,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] sel_out,
  output logic [CH-1:0]   onehot,
  output logic            valid,
  output logic            busy,
  output logic            done,
  output logic            dbgRun   // sweep FSM state: 1 while in RUN
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_SWEEP  = 2'b11;

  localparam logic [SELW-1:0] LAST_SEL = SELW'(CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweepStateT;

  sweepStateT      state, stateNxt;
  logic [SELW-1:0] selNxt;
  logic            update;
  logic            validNxt, busyNxt, doneNxt;
  logic [W-1:0]    dataNxt;
  logic [CH-1:0]   onehotNxt;

  assign dbgRun = (state == RUN);

  // Next-select and status rules. Any mode other than sweep forces the FSM
  // to IDLE, which both aborts a running sweep and guarantees that entering
  // sweep mode later begins from IDLE.
  always_comb begin
    stateNxt = IDLE;
    selNxt   = sel_out;
    update   = 1'b0;
    validNxt = 1'b0;
    busyNxt  = 1'b0;
    doneNxt  = 1'b0;
    case (mode)
      MODE_HOLD: begin
        update = 1'b0;
      end
      MODE_MANUAL: begin
        selNxt   = load ? sel_in : sel_out;
        update   = 1'b1;
        validNxt = 1'b1;
      end
      MODE_AUTO: begin
        selNxt   = sel_out + 1'b1;
        update   = 1'b1;
        validNxt = 1'b1;
      end
      MODE_SWEEP: begin
        if (state == IDLE) begin
          if (start) begin
            selNxt   = '0;
            update   = 1'b1;
            validNxt = 1'b1;
            busyNxt  = 1'b1;
            stateNxt = RUN;
          end
        end else begin
          // start is deliberately ignored while a sweep is running
          selNxt   = sel_out + 1'b1;
          update   = 1'b1;
          validNxt = 1'b1;
          if (selNxt == LAST_SEL) begin
            doneNxt  = 1'b1;
            stateNxt = IDLE;
          end else begin
            busyNxt  = 1'b1;
            stateNxt = RUN;
          end
        end
      end
      default: begin
        update = 1'b0;
      end
    endcase
  end

  // Channel data and one-hot decode for the select value about to be loaded.
  always_comb begin
    dataNxt   = '0;
    onehotNxt = '0;
    for (int k = 0; k < CH; k++) begin
      if (selNxt == SELW'(k)) begin
        dataNxt      = din[k*W +: W];
        onehotNxt[k] = 1'b1;
      end
    end
  end

  // State and output registers; select/data/decode only move when update is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_out <= '0;
      dout    <= '0;
      onehot  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= stateNxt;
      valid <= validNxt;
      busy  <= busyNxt;
      done  <= doneNxt;
      if (update) begin
        sel_out <= selNxt;
        dout    <= dataNxt;
        onehot  <= onehotNxt;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux with CH=8, W=4 and channel k carrying k+3.
module tb_scan_mux;

  localparam int CH   = 8;
  localparam int W    = 4;
  localparam int SELW = 3;

  logic            clk;
  logic            rst;
  logic [CH*W-1:0] din;
  logic [1:0]      mode;
  logic [SELW-1:0] sel_in;
  logic            load;
  logic            start;
  logic [W-1:0]    dout;
  logic [SELW-1:0] sel_out;
  logic [CH-1:0]   onehot;
  logic            valid;
  logic            busy;
  logic            done;
  logic            dbgRun;

  int vectors;
  int miscompares;

  scan_mux #(.CH(CH), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .mode    (mode),
    .sel_in  (sel_in),
    .load    (load),
    .start   (start),
    .dout    (dout),
    .sel_out (sel_out),
    .onehot  (onehot),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .dbgRun  (dbgRun)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int expSel, input int expDout,
                          input int expOnehot, input bit expValid,
                          input bit expBusy, input bit expDone);
    check({tag, ".sel_out"}, 32'(sel_out), 32'(expSel));
    check({tag, ".dout"},    32'(dout),    32'(expDout));
    check({tag, ".onehot"},  32'(onehot),  32'(expOnehot));
    check({tag, ".valid"},   32'(valid),   32'(expValid));
    check({tag, ".busy"},    32'(busy),    32'(expBusy));
    check({tag, ".done"},    32'(done),    32'(expDone));
  endtask

  task automatic setDefaultDin();
    for (int k = 0; k < CH; k++) din[k*W +: W] = W'(k + 3);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    mode   = 2'b10;
    sel_in = '0;
    load   = 1'b0;
    start  = 1'b0;
    din    = '0;
    setDefaultDin();

    // reset held two cycles in auto-scan: everything zero
    step();
    checkAll("rst0", 0, 0, 8'h00, 0, 0, 0);
    step();
    checkAll("rst1", 0, 0, 8'h00, 0, 0, 0);
    check("rst1.fsm", 32'(dbgRun), 32'd0);

    // first edge after release applies auto-scan rule
    rst = 1'b0;
    step();
    checkAll("auto1", 1, 4, 8'h02, 1, 0, 0);

    // auto-scan continues to ten edges: 2..7, 0, 1, 2
    for (int i = 2; i <= 10; i++) begin
      step();
      checkAll($sformatf("auto%0d", i), i % 8, (i % 8) + 3, 1 << (i % 8), 1, 0, 0);
    end

    // manual: load channel 5, then hold it with load low
    mode = 2'b01; load = 1'b1; sel_in = 3'd5;
    step();
    checkAll("man_load", 5, 8, 8'h20, 1, 0, 0);
    load = 1'b0; sel_in = 3'd2;
    step();
    checkAll("man_keep", 5, 8, 8'h20, 1, 0, 0);
    din[5*W +: W] = 4'hF;
    step();
    checkAll("man_track", 5, 15, 8'h20, 1, 0, 0);

    // hold: outputs frozen even though channel data changes back
    mode = 2'b00;
    setDefaultDin();
    step();
    checkAll("hold", 5, 15, 8'h20, 0, 0, 0);

    // sweep idle without start: retain, not valid
    mode = 2'b11;
    step();
    checkAll("sw_idle", 5, 15, 8'h20, 0, 0, 0);
    check("sw_idle.fsm", 32'(dbgRun), 32'd0);

    // full sweep
    start = 1'b1;
    step();
    checkAll("sw0", 0, 3, 8'h01, 1, 1, 0);
    check("sw0.fsm", 32'(dbgRun), 32'd1);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checkAll($sformatf("sw%0d", k), k, k + 3, 1 << k, 1, 1, 0);
    end
    step();
    checkAll("sw7", 7, 10, 8'h80, 1, 0, 1);
    check("sw7.fsm", 32'(dbgRun), 32'd0);
    step();
    checkAll("sw_after", 7, 10, 8'h80, 0, 0, 0);

    // abort: three samples, start during RUN ignored, then switch to hold
    start = 1'b1;
    step();
    checkAll("ab0", 0, 3, 8'h01, 1, 1, 0);
    start = 1'b0;
    step();
    checkAll("ab1", 1, 4, 8'h02, 1, 1, 0);
    start = 1'b1;
    step();
    checkAll("ab2_start_ignored", 2, 5, 8'h04, 1, 1, 0);
    start = 1'b0; mode = 2'b00;
    step();
    checkAll("ab_hold", 2, 5, 8'h04, 0, 0, 0);
    check("ab_hold.fsm", 32'(dbgRun), 32'd0);
    step();
    checkAll("ab_hold2", 2, 5, 8'h04, 0, 0, 0);
    mode = 2'b11;
    step();
    checkAll("ab_reenter_idle", 2, 5, 8'h04, 0, 0, 0);
    check("ab_reenter.fsm", 32'(dbgRun), 32'd0);

    // reset mid-sweep at channel 4, then restart from channel 0
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    checkAll("mid4", 4, 7, 8'h10, 1, 1, 0);
    rst = 1'b1;
    step();
    checkAll("mid_rst", 0, 0, 8'h00, 0, 0, 0);
    check("mid_rst.fsm", 32'(dbgRun), 32'd0);
    rst = 1'b0;
    step();
    checkAll("mid_idle", 0, 0, 8'h00, 0, 0, 0);
    start = 1'b1;
    step();
    checkAll("restart0", 0, 3, 8'h01, 1, 1, 0);
    start = 1'b0;
    step();
    checkAll("restart1", 1, 4, 8'h02, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The module SHALL have parameter CH, default 8, number of input channels (power of two, 2..64).
REQ-002 The module SHALL have parameter W, default 1, per-channel data width.
REQ-003 The module SHALL have parameter SELW, default $clog2(CH), select width (derived; not overridden).
REQ-004 The module SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have port din  input  CH*W  packed channels; channel k = din[k*W +: W].
REQ-007 The module SHALL have port mode  input  2  00 hold, 01 manual, 10 auto-scan, 11 sweep.
REQ-008 The module SHALL have port sel_in  input  SELW  manual channel index.
REQ-009 The module SHALL have port load  input  1  manual mode: capture sel_in.
REQ-010 The module SHALL have port start  input  1  sweep mode: begin one sweep.
REQ-011 The module SHALL have port dout  output  W  registered selected channel data.
REQ-012 The module SHALL have port sel_out  output  SELW  current select register.
REQ-013 The module SHALL have port onehot  output  CH  registered active-high decode of sel_out.
REQ-014 The module SHALL have ports valid, busy, done  output  1 each  sample valid / sweep active / sweep-complete pulse.

Function
REQ-015 Each edge the block SHALL compute sel_nxt per mode, then register sel_out<=sel_nxt, dout<=channel(sel_nxt) sampled that edge, onehot<=decode(sel_nxt); latency one cycle from din to dout.
REQ-016 onehot SHALL always have exactly bit sel_out set, except after reset/hold-from-reset (all zero).
REQ-017 Hold (00): sel_out, dout, onehot SHALL retain value; valid<=0; busy<=0; done<=0.
REQ-018 Manual (01): sel_nxt = load ? sel_in : sel_out; valid<=1 every cycle; dout tracks selected channel each cycle.
REQ-019 Auto-scan (10): sel_nxt = sel_out+1 modulo CH (CH-1 wraps to 0); valid<=1 every cycle.
REQ-020 Sweep (11) states: IDLE, RUN.
REQ-021 IDLE with start=0: sel/dout/onehot retain, valid<=0, busy<=0, done<=0.
REQ-022 IDLE with start=1: sel_nxt=0, busy<=1, valid<=1, -> RUN.
REQ-023 RUN: sel_nxt=sel_out+1; valid<=1; start ignored.
REQ-024 RUN when sel_nxt==CH-1: busy<=0, done<=1 for that one cycle, -> IDLE; sweep yields exactly CH samples, channels 0..CH-1, on CH consecutive cycles.
REQ-025 done SHALL be a single-cycle pulse, asserted only coincident with the channel CH-1 sample of a completed sweep.
REQ-026 Mode change while RUN SHALL abort: state -> IDLE, busy<=0, done stays 0; new mode's rule applies on that same edge.
REQ-027 Entering sweep mode from another mode SHALL start in IDLE.
REQ-028 Unknown/X inputs outside the defined rules SHALL NOT be decoded specially; behaviour for legal encodings only is required.

Reset
REQ-029 rst=1 at an edge SHALL force sel_out=0, dout=0, onehot=0, valid=0, busy=0, done=0, sweep state IDLE, overriding all other inputs, including mid-sweep.
REQ-030 First edge with rst=0 SHALL apply normal mode rules.

Verification (CH=8, W=4, din channel k = k+3)
REQ-031 Reset: rst=1 two cycles, mode=10 -> all outputs 0 during reset; first edge after release sel_out=1, dout=4, onehot=0x02, valid=1.
REQ-032 Auto-scan wrap: mode=10 for 10 edges from reset -> sel_out 1..7,0,1,2; dout follows k+3; onehot=0x01 at wrap.
REQ-033 Manual: mode=01, load=1 sel_in=5 one edge, then load=0 sel_in=2 -> sel_out=5, dout=8 held; change channel 5 to 0xF -> dout=0xF next edge.
REQ-034 Sweep: mode=11, start=1 one cycle -> busy high 7 cycles, sel_out 0..7, done=1 only with sel_out=7 dout=10, then valid=0, busy=0.
REQ-035 Sweep abort/restart: start, after 3 samples switch mode=00 -> busy=0, done never 1, outputs hold; start asserted during RUN has no effect.
REQ-036 Reset mid-sweep: rst=1 at sel_out=4 -> all outputs 0, next start restarts sweep at channel 0.
